// File: rtl/parallella_gpio_arbiter.sv
// Shares the 48 PS/EMIO GPIO pins between the PS and one PL requester with a req/gnt
// handshake, a forced high-Z turnaround between owners and a synchronised pad input path.
module parallella_gpio_arbiter #(
  parameter logic [47:0] PL_MASK     = 48'hFFFF_FF00_0000,
  parameter int          TURN_CYC    = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [47:0] i_ps_gpio_o,
  input  logic [47:0] i_ps_gpio_t,
  output logic [47:0] o_ps_gpio_i,
  input  logic        i_ps_hold,
  input  logic        i_pl_req,
  output logic        o_pl_gnt,
  input  logic [47:0] i_pl_gpio_o,
  input  logic [47:0] i_pl_gpio_t,
  output logic [47:0] o_pl_gpio_i,
  output logic [47:0] o_pad_gpio_o,
  output logic [47:0] o_pad_gpio_t,
  input  logic [47:0] i_pad_gpio_i,
  output logic [1:0]  o_owner
);
  // state | meaning: PS_OWN ps drives | TURN_TO_PL masked hi-Z | PL_OWN pl drives | TURN_TO_PS masked hi-Z
  typedef enum logic [1:0] {
    PS_OWN     = 2'b00,
    TURN_TO_PL = 2'b01,
    PL_OWN     = 2'b10,
    TURN_TO_PS = 2'b11
  } state_t;

  localparam logic [7:0] TURN_LOAD = 8'(TURN_CYC - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_cnt;
  logic [7:0]  w_next_cnt;
  logic        r_pl_gnt;
  logic [47:0] r_pad_o;
  logic [47:0] r_pad_t;
  logic [47:0] r_sync [SYNC_STAGES];
  logic        w_release;
  logic [47:0] w_msk_o;
  logic [47:0] w_msk_t;
  logic [47:0] w_pad_o;
  logic [47:0] w_pad_t;

  assign w_release = ~i_pl_req | i_ps_hold;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      PS_OWN: begin
        if (!w_release) begin
          w_next_state = TURN_TO_PL;
          w_next_cnt   = TURN_LOAD;
        end
      end
      TURN_TO_PL: begin
        if (w_release)           w_next_state = PS_OWN;
        else if (r_cnt == 8'd0)  w_next_state = PL_OWN;
        else                     w_next_cnt   = r_cnt - 8'd1;
      end
      PL_OWN: begin
        if (w_release) begin
          w_next_state = TURN_TO_PS;
          w_next_cnt   = TURN_LOAD;
        end
      end
      TURN_TO_PS: begin
        if (r_cnt == 8'd0) w_next_state = PS_OWN;
        else               w_next_cnt   = r_cnt - 8'd1;
      end
      default: begin
        w_next_state = PS_OWN;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Masked pins are driven only when ownership is stable across the edge, otherwise high-Z.
  always_comb begin
    w_msk_o = '0;
    w_msk_t = '1;
    if (r_state == PS_OWN && w_next_state == PS_OWN) begin
      w_msk_o = i_ps_gpio_o;
      w_msk_t = i_ps_gpio_t;
    end else if (r_state == PL_OWN && w_next_state == PL_OWN) begin
      w_msk_o = i_pl_gpio_o;
      w_msk_t = i_pl_gpio_t;
    end
  end

  assign w_pad_o = (i_ps_gpio_o & ~PL_MASK) | (w_msk_o & PL_MASK);
  assign w_pad_t = (i_ps_gpio_t & ~PL_MASK) | (w_msk_t & PL_MASK);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= PS_OWN;
      r_cnt    <= '0;
      r_pl_gnt <= 1'b0;
      r_pad_o  <= '0;
      r_pad_t  <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_pl_gnt <= (w_next_state == PL_OWN);
      r_pad_o  <= w_pad_o;
      r_pad_t  <= w_pad_t;
      r_sync[0] <= i_pad_gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_ps_gpio_i  = r_sync[SYNC_STAGES-1];
  assign o_pl_gpio_i  = (r_state == PL_OWN) ? (r_sync[SYNC_STAGES-1] & PL_MASK) : '0;
  assign o_pl_gnt     = r_pl_gnt;
  assign o_pad_gpio_o = r_pad_o;
  assign o_pad_gpio_t = r_pad_t;
  assign o_owner      = r_state;

endmodule

// File: tb/tb_parallella_gpio_arbiter.sv
// Bench for parallella_gpio_arbiter: directed vector table, hand sequences for the
// synchroniser, then random stimulus against a cycle-level ownership model.
module tb_parallella_gpio_arbiter;
  localparam logic [47:0] MASK = 48'hFFFF_FF00_0000;
  localparam int TC = 4;
  localparam int SS = 2;

  localparam logic [47:0] PS_O = 48'h5A5A_5A00_00A5;
  localparam logic [47:0] PS_T = 48'h0000_0000_0000;
  localparam logic [47:0] PL_O = 48'hABCD_EF12_3456;
  localparam logic [47:0] PL_T = 48'h0F0F_0000_FFFF;

  logic        clk = 1'b0;
  logic        reset, ps_hold, pl_req;
  logic [47:0] ps_gpio_o, ps_gpio_t, pl_gpio_o, pl_gpio_t, pad_gpio_i;
  logic [47:0] ps_gpio_i, pl_gpio_i, pad_gpio_o, pad_gpio_t;
  logic        pl_gnt;
  logic [1:0]  owner;

  int total = 0;
  int bad = 0;

  parallella_gpio_arbiter dut (
    .i_clk(clk), .i_reset(reset),
    .i_ps_gpio_o(ps_gpio_o), .i_ps_gpio_t(ps_gpio_t), .o_ps_gpio_i(ps_gpio_i),
    .i_ps_hold(ps_hold), .i_pl_req(pl_req), .o_pl_gnt(pl_gnt),
    .i_pl_gpio_o(pl_gpio_o), .i_pl_gpio_t(pl_gpio_t), .o_pl_gpio_i(pl_gpio_i),
    .o_pad_gpio_o(pad_gpio_o), .o_pad_gpio_t(pad_gpio_t), .i_pad_gpio_i(pad_gpio_i),
    .o_owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner code, edges spent in a turnaround, pad input history.
  int          m_st = 0;
  int          m_spent = 0;
  logic [47:0] m_hist[$];
  logic [47:0] m_pad_o = '0, m_pad_t = '1, m_ps_i = '0, m_pl_i = '0;
  logic        m_gnt = 1'b0;

  task automatic model_edge();
    int nx;
    logic [47:0] so, st;
    if (reset) begin
      m_st = 0; m_spent = 0; m_hist.delete();
      m_pad_o = '0; m_pad_t = '1; m_gnt = 1'b0; m_ps_i = '0; m_pl_i = '0;
      return;
    end
    nx = m_st;
    case (m_st)
      0: if (pl_req && !ps_hold) begin nx = 1; m_spent = 0; end
      1: if (!pl_req || ps_hold) nx = 0;
         else if (m_spent + 1 == TC) nx = 2;
         else m_spent++;
      2: if (!pl_req || ps_hold) begin nx = 3; m_spent = 0; end
      default: if (m_spent + 1 == TC) nx = 0; else m_spent++;
    endcase
    if (m_st == 0 && nx == 0)      begin so = ps_gpio_o; st = ps_gpio_t; end
    else if (m_st == 2 && nx == 2) begin so = pl_gpio_o; st = pl_gpio_t; end
    else                           begin so = '0;        st = '1;        end
    m_pad_o = (ps_gpio_o & ~MASK) | (so & MASK);
    m_pad_t = (ps_gpio_t & ~MASK) | (st & MASK);
    m_gnt = (nx == 2);
    m_st = nx;
    m_hist.push_back(pad_gpio_i);
    if (m_hist.size() > SS) void'(m_hist.pop_front());
    m_ps_i = (m_hist.size() == SS) ? m_hist[0] : '0;
    m_pl_i = (m_st == 2) ? (m_ps_i & MASK) : '0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("m_owner", {46'd0, owner}, 48'(m_st));
    chk("m_gnt", {47'd0, pl_gnt}, {47'd0, m_gnt});
    chk("m_pad_o", pad_gpio_o, m_pad_o);
    chk("m_pad_t", pad_gpio_t, m_pad_t);
    chk("m_ps_i", ps_gpio_i, m_ps_i);
    chk("m_pl_i", pl_gpio_i, m_pl_i);
  endtask

  typedef struct {
    bit       rst;
    bit       req;
    bit       hold;
    bit [1:0] own;
    bit       gnt;
    int       kind;   // 0 PS pads, 1 masked hi-Z, 2 PL pads, 3 all hi-Z
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit rst, input bit req, input bit hold,
                     input bit [1:0] own, input bit gnt, input int kind, input int n);
    vec_t v;
    v.rst = rst; v.req = req; v.hold = hold; v.own = own; v.gnt = gnt; v.kind = kind;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  function automatic logic [95:0] pads_for(input int kind);
    case (kind)
      0:       return {48'h5A5A_5A00_00A5, 48'h0000_0000_0000};
      1:       return {48'h0000_0000_00A5, 48'hFFFF_FF00_0000};
      2:       return {48'hABCD_EF00_00A5, 48'h0F0F_0000_0000};
      default: return {48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF};
    endcase
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  initial begin
    logic [95:0] pp;
    reset = 1'b1; ps_hold = 1'b0; pl_req = 1'b0;
    ps_gpio_o = PS_O; ps_gpio_t = PS_T; pl_gpio_o = PL_O; pl_gpio_t = PL_T;
    pad_gpio_i = '0;

    // rst req hold | owner gnt kind | repeat
    add(1,0,0, 0,0,3, 1);
    add(0,0,0, 0,0,0, 1);
    add(0,1,0, 1,0,1, 4);          // TURN_TO_PL for TURN_CYC edges
    add(0,1,0, 2,1,1, 1);          // grant edge, pads still hi-Z
    add(0,1,0, 2,1,2, 1);          // PL drives one edge later
    add(0,0,0, 3,0,1, 4);          // release: TURN_TO_PS
    add(0,0,0, 0,0,1, 1);
    add(0,0,0, 0,0,0, 1);          // PS values return
    add(0,1,0, 1,0,1, 4);
    add(0,1,0, 2,1,1, 1);
    add(0,1,0, 2,1,2, 1);
    add(0,0,0, 3,0,1, 1);
    add(0,1,0, 3,0,1, 3);          // re-request ignored in TURN_TO_PS
    add(0,1,0, 0,0,1, 1);          // mandatory PS_OWN cycle
    add(0,1,0, 1,0,1, 4);
    add(0,1,0, 2,1,1, 1);
    add(0,1,0, 2,1,2, 1);
    add(0,1,1, 3,0,1, 4);          // PS hold revokes with req high
    add(0,1,1, 0,0,1, 1);
    add(0,1,1, 0,0,0, 2);          // no re-grant while held
    add(0,1,0, 1,0,1, 2);          // counter now at 2
    add(0,0,0, 0,0,1, 1);          // abort, no grant
    add(0,0,0, 0,0,0, 1);
    add(0,1,0, 1,0,1, 4);
    add(0,1,0, 2,1,1, 1);
    add(0,1,0, 2,1,2, 1);
    add(1,1,0, 0,0,3, 1);          // reset mid-grant
    add(0,0,0, 0,0,0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; pl_req = vecs[i].req; ps_hold = vecs[i].hold;
      step();
      pp = pads_for(vecs[i].kind);
      chk($sformatf("v%0d_owner", i), {46'd0, owner}, {46'd0, vecs[i].own});
      chk($sformatf("v%0d_gnt", i), {47'd0, pl_gnt}, {47'd0, vecs[i].gnt});
      chk($sformatf("v%0d_pad_o", i), pad_gpio_o, pp[95:48]);
      chk($sformatf("v%0d_pad_t", i), pad_gpio_t, pp[47:0]);
    end

    // Synchroniser latency and PL input gating on bit 30 (masked) and bit 5 (unmasked).
    pad_gpio_i = 48'h0000_4000_0020;
    step();
    chk("sync30_e1", {47'd0, ps_gpio_i[30]}, 48'd0);
    step();
    chk("sync30_e2", {47'd0, ps_gpio_i[30]}, 48'd1);
    chk("pl_i_ungranted", pl_gpio_i, 48'd0);
    pl_req = 1'b1;
    for (int i = 0; i < TC + 1; i++) step();
    chk("gnt_for_sync", {47'd0, pl_gnt}, 48'd1);
    chk("pl_i_granted", pl_gpio_i, 48'h0000_4000_0000);
    pad_gpio_i = '0;
    step();
    chk("pl_i30_hold", {47'd0, pl_gpio_i[30]}, 48'd1);
    step();
    chk("pl_i30_fall", {47'd0, pl_gpio_i[30]}, 48'd0);
    pad_gpio_i = 48'h0000_4000_0020;
    pl_req = 1'b0;
    step();
    chk("pl_i_revoked", pl_gpio_i, 48'd0);
    step();
    chk("ps_i_after_revoke", ps_gpio_i, 48'h0000_4000_0020);
    chk("pl_i5_zero", {47'd0, pl_gpio_i[5]}, 48'd0);

    // Random stimulus against the model.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)   pl_req = ~pl_req;
      if ($urandom_range(0, 23) == 0)  ps_hold = ~ps_hold;
      reset = ($urandom_range(0, 299) == 0);
      ps_gpio_o = rnd48(); ps_gpio_t = rnd48();
      pl_gpio_o = rnd48(); pl_gpio_t = rnd48();
      pad_gpio_i = rnd48();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
